// File: rtl/first_system_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// first_system_sweep_ctrl
//
// Hardware sequencer for a first_system instance. On an accepted start it
// steps the input vector {dut_in1,dut_in2} through 2'b00, 2'b01, ... for
// NUM_STEPS vectors. Each vector is held for SETTLE_CYCLES cycles and then
// {dut_out1,dut_out2} is captured into its 2-bit slot of 'results'.
// A sweep therefore costs SETTLE_CYCLES+1 cycles per vector.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before capture (>= 1)
//   NUM_STEPS      number of vectors swept, starting at 2'b00 (1..4)
//
// Ports
//   clk          in   1  clock, all logic on the rising edge
//   rst          in   1  synchronous reset, active high
//   start        in   1  begins a sweep, only looked at in IDLE
//   abort        in   1  cancels a sweep in progress (SETTLE/CAPTURE/DONE)
//   dut_out1     in   1  first_system out1
//   dut_out2     in   1  first_system out2
//   dut_in1      out  1  first_system in1 (registered)
//   dut_in2      out  1  first_system in2 (registered)
//   busy         out  1  high while in SETTLE or CAPTURE
//   done         out  1  one-cycle pulse when a sweep completes
//   step_idx     out  2  index of the vector currently driven
//   results      out  8  slot i = results[2i+1:2i] = {out1,out2} of vector i
//
// Optional build macro SWEEP_CHECK_EN adds:
//   exp_results  in   8  expected pack, same layout as results
//   mismatch     out  4  bit i set when captured slot i differs from expected
//   pass         out  1  set together with done when no slot mismatched
// -----------------------------------------------------------------------------
module first_system_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_STEPS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out1,
    input  logic       dut_out2,
`ifdef SWEEP_CHECK_EN
    input  logic [7:0] exp_results,
    output logic [3:0] mismatch,
    output logic       pass,
`endif
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       busy,
    output logic       done,
    output logic [1:0] step_idx,
    output logic [7:0] results
);

    // Counter is one bit wider than strictly needed so the increment on the
    // last settle cycle never wraps.
    localparam int               CNT_W     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [1:0]       STEP_LAST = 2'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Replace the 2-bit slot 'idx' of a results pack with 'val'.
    function automatic logic [7:0] slot_write(input logic [7:0] pack,
                                              input logic [1:0] idx,
                                              input logic [1:0] val);
        logic [7:0] upd;
        upd = pack;
        case (idx)
            2'd0:    upd[1:0] = val;
            2'd1:    upd[3:2] = val;
            2'd2:    upd[5:4] = val;
            2'd3:    upd[7:6] = val;
            default: upd      = pack;
        endcase
        return upd;
    endfunction

    // Read the 2-bit slot 'idx' out of a results pack.
    function automatic logic [1:0] slot_get(input logic [7:0] pack,
                                            input logic [1:0] idx);
        logic [1:0] val;
        case (idx)
            2'd0:    val = pack[1:0];
            2'd1:    val = pack[3:2];
            2'd2:    val = pack[5:4];
            2'd3:    val = pack[7:6];
            default: val = 2'b00;
        endcase
        return val;
    endfunction

    // One-hot flag for slot 'idx'.
    function automatic logic [3:0] slot_bit(input logic [1:0] idx);
        logic [3:0] flag;
        case (idx)
            2'd0:    flag = 4'b0001;
            2'd1:    flag = 4'b0010;
            2'd2:    flag = 4'b0100;
            2'd3:    flag = 4'b1000;
            default: flag = 4'b0000;
        endcase
        return flag;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r,   cnt_s;
    logic [1:0]       vec_r,   vec_s;
    logic [1:0]       step_r,  step_s;
    logic [7:0]       res_r,   res_s;
    logic             busy_r,  busy_s;
    logic             done_r,  done_s;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        vec_s   = vec_r;
        step_s  = step_r;
        res_s   = res_r;

        case (state_r)
            ST_IDLE: begin
                // abort together with start cancels the request outright
                if (start && !abort) begin
                    res_s   = 8'h00;
                    vec_s   = 2'b00;
                    step_s  = 2'd0;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    vec_s   = 2'b00;
                    step_s  = 2'd0;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = ST_CAPTURE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = ST_SETTLE;
                end
            end

            ST_CAPTURE: begin
                // abort wins over the capture: the current slot stays 0
                if (abort) begin
                    vec_s   = 2'b00;
                    step_s  = 2'd0;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_IDLE;
                end else begin
                    res_s = slot_write(res_r, step_r, {dut_out1, dut_out2});
                    if (step_r == STEP_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        vec_s   = vec_r + 2'b01;
                        step_s  = step_r + 2'd1;
                        cnt_s   = CNT_ZERO;
                        state_s = ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                // last vector stays driven unless the sweep is aborted here
                if (abort) begin
                    vec_s   = 2'b00;
                    step_s  = 2'd0;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            default: begin
                vec_s   = 2'b00;
                step_s  = 2'd0;
                cnt_s   = CNT_ZERO;
                state_s = ST_IDLE;
            end
        endcase

        // Status flags follow the state being entered so they can be registered.
        busy_s = (state_s == ST_SETTLE) || (state_s == ST_CAPTURE);
        done_s = (state_s == ST_DONE);
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            vec_r   <= 2'b00;
            step_r  <= 2'd0;
            res_r   <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            vec_r   <= vec_s;
            step_r  <= step_s;
            res_r   <= res_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign dut_in1  = vec_r[1];
    assign dut_in2  = vec_r[0];
    assign busy     = busy_r;
    assign done     = done_r;
    assign step_idx = step_r;
    assign results  = res_r;

`ifdef SWEEP_CHECK_EN
    logic [3:0] mism_r, mism_s, mism_cap_s;
    logic       pass_r, pass_s;

    // Mismatch flags and pass verdict, updated alongside the sweep.
    always_comb begin
        mism_s = mism_r;
        pass_s = pass_r;

        if (slot_get(exp_results, step_r) != {dut_out1, dut_out2}) begin
            mism_cap_s = mism_r | slot_bit(step_r);
        end else begin
            mism_cap_s = mism_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    mism_s = 4'b0000;
                    pass_s = 1'b0;
                end else begin
                    mism_s = mism_r;
                    pass_s = pass_r;
                end
            end

            ST_CAPTURE: begin
                if (abort) begin
                    mism_s = mism_r;
                    pass_s = pass_r;
                end else begin
                    mism_s = mism_cap_s;
                    // verdict lands in the same cycle done rises
                    if (step_r == STEP_LAST) begin
                        pass_s = (mism_cap_s == 4'b0000);
                    end else begin
                        pass_s = pass_r;
                    end
                end
            end

            default: begin
                mism_s = mism_r;
                pass_s = pass_r;
            end
        endcase
    end

    // Mismatch / pass registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mism_r <= 4'b0000;
            pass_r <= 1'b0;
        end else begin
            mism_r <= mism_s;
            pass_r <= pass_s;
        end
    end

    assign mismatch = mism_r;
    assign pass     = pass_r;
`endif

endmodule

// File: tb/tb_first_system_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for first_system_sweep_ctrl. The first_system stand-in is a 2-bit
// lookup table indexed by the driven vector; the default table 8'h94 is
// out1=in1&in2, out2=in1^in2. A second instance runs with NUM_STEPS=2,
// SETTLE_CYCLES=1.
// -----------------------------------------------------------------------------
module tb_first_system_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       dut_out1, dut_out2, dut_in1, dut_in2, busy, done;
    logic [1:0] step_idx;
    logic [7:0] results;
    logic [7:0] lut;

    logic       start2, abort2;
    logic       d2_out1, d2_out2, d2_in1, d2_in2, busy2, done2;
    logic [1:0] step2;
    logic [7:0] results2;

`ifdef SWEEP_CHECK_EN
    logic [7:0] exp_results;
    logic [3:0] mismatch, mismatch2;
    logic       pass, pass2;
`endif

    int total = 0;
    int bad   = 0;
    int done_total  = 0;
    int done2_total = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] lut_slot(input logic [7:0] pk, input logic [1:0] idx);
        int i;
        i = int'(idx);
        return pk[2*i +: 2];
    endfunction

    assign {dut_out1, dut_out2} = lut_slot(lut, {dut_in1, dut_in2});
    assign d2_out1 = d2_in1 & d2_in2;
    assign d2_out2 = d2_in1 ^ d2_in2;

    first_system_sweep_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_out1(dut_out1), .dut_out2(dut_out2),
`ifdef SWEEP_CHECK_EN
        .exp_results(exp_results), .mismatch(mismatch), .pass(pass),
`endif
        .dut_in1(dut_in1), .dut_in2(dut_in2), .busy(busy), .done(done),
        .step_idx(step_idx), .results(results)
    );

    first_system_sweep_ctrl #(.SETTLE_CYCLES(1), .NUM_STEPS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .dut_out1(d2_out1), .dut_out2(d2_out2),
`ifdef SWEEP_CHECK_EN
        .exp_results(exp_results), .mismatch(mismatch2), .pass(pass2),
`endif
        .dut_in1(d2_in1), .dut_in2(d2_in2), .busy(busy2), .done(done2),
        .step_idx(step2), .results(results2)
    );

    // count done pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (done)  done_total  <= done_total + 1;
        if (done2) done2_total <= done2_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, vec, step} expected j edges after the start-sampling edge,
    // default parameters: 5 edges per vector, done right after edge 20.
    function automatic logic [5:0] sweep_expect(input int j);
        logic [1:0] v;
        if (j < 20) begin
            v = 2'(j / 5);
            return {1'b1, 1'b0, v, v};
        end else if (j == 20) begin
            return {1'b0, 1'b1, 2'b11, 2'b11};
        end else begin
            return {1'b0, 1'b0, 2'b11, 2'b11};
        end
    endfunction

    // Reference: slot i is captured at edge 5*(i+1); an abort sampled at
    // edge k (k=0 means none) keeps only slots captured strictly before k.
    function automatic logic [7:0] model_results(input logic [7:0] l, input int k);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (k == 0 || 5 * (i + 1) < k) r[2*i +: 2] = l[2*i +: 2];
        end
        return r;
    endfunction

    // Pulse start, then run 24 further edges with abort sampled at edge k.
    task automatic run_sweep(input int k, input logic [7:0] l);
        lut   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            abort = (j == k);
            tick();
        end
        abort = 1'b0;
    endtask

    typedef struct {
        int         abort_edge;
        logic [7:0] lut;
        logic [7:0] exp_res;
        int         exp_done;
        logic [1:0] exp_vec;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int d0;
        int k;
        logic [7:0] l;

        tbl[0] = '{0,  8'h94, 8'h94, 1, 2'b11};  // full sweep
        tbl[1] = '{18, 8'h94, 8'h14, 0, 2'b00};  // abort in SETTLE of vector 3
        tbl[2] = '{10, 8'hA5, 8'h01, 0, 2'b00};  // abort beats capture of slot 1
        tbl[3] = '{11, 8'hA5, 8'h05, 0, 2'b00};  // abort right after slot 1
        tbl[4] = '{1,  8'hFF, 8'h00, 0, 2'b00};  // abort on first settle cycle
        tbl[5] = '{21, 8'h3C, 8'h3C, 1, 2'b00};  // abort in DONE
        tbl[6] = '{0,  8'h5A, 8'h5A, 1, 2'b11};  // full sweep, other table
        tbl[7] = '{20, 8'h94, 8'h14, 0, 2'b00};  // abort beats the last capture

        lut    = 8'h94;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        start2 = 1'b0;
        abort2 = 1'b0;
`ifdef SWEEP_CHECK_EN
        exp_results = 8'h94;
`endif
        tick();
        tick();
        check("reset_outputs", {dut_in1, dut_in2, busy, done, step_idx, results}, 32'h0);
        check("reset_outputs2", {d2_in1, d2_in2, busy2, done2, step2, results2}, 32'h0);
`ifdef SWEEP_CHECK_EN
        check("reset_check", {mismatch, pass}, 32'h0);
`endif
        rst = 1'b0;
        tick();

        // table-driven sweeps
        for (int t = 0; t < 8; t++) begin
            d0 = done_total;
            run_sweep(tbl[t].abort_edge, tbl[t].lut);
            check($sformatf("tbl%0d_results", t), results, tbl[t].exp_res);
            check($sformatf("tbl%0d_done", t), done_total - d0, tbl[t].exp_done);
            check($sformatf("tbl%0d_idle", t), {busy, dut_in1, dut_in2, step_idx},
                  {1'b0, tbl[t].exp_vec, tbl[t].exp_vec});
        end

        // start held high: cycle-exact sweep, then a second sweep only after DONE->IDLE
        lut   = 8'h94;
        start = 1'b1;
        tick();
        for (int j = 0; j <= 26; j++) begin
            if (j > 0) tick();
            check($sformatf("held_cyc%0d", j), {busy, done, dut_in1, dut_in2, step_idx},
                  (j < 22) ? sweep_expect(j) : sweep_expect(j - 22));
            if (j == 20) check("held_results_done", results, 8'h94);
            if (j == 22) check("held_results_clear", results, 8'h00);
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("held_abort_idle", {busy, dut_in1, dut_in2, step_idx}, 32'h0);

        // synchronous reset during CAPTURE of vector 1, with start in the same cycle
        lut   = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 9; j++) tick();
        check("pre_rst_state", {busy, step_idx, results}, {1'b1, 2'd1, 8'h03});
        rst   = 1'b1;
        start = 1'b1;
        tick();
        check("rst_in_capture", {dut_in1, dut_in2, busy, done, step_idx, results}, 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst_start_ignored", {busy, dut_in1, dut_in2, results}, 32'h0);

        // short instance: 2 vectors, 1 settle cycle
        d0     = done2_total;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick(); tick(); tick();
        check("short_e3", {busy2, done2, d2_in1, d2_in2}, {1'b1, 1'b0, 2'b01});
        tick();
        check("short_e4", {busy2, done2, d2_in1, d2_in2, step2, results2},
              {1'b0, 1'b1, 2'b01, 2'd1, 8'h04});
        tick();
        check("short_done_count", done2_total - d0, 1);

`ifdef SWEEP_CHECK_EN
        exp_results = 8'h94;
        run_sweep(0, 8'h94);
        check("chk_pass", {mismatch, pass}, {4'b0000, 1'b1});
        exp_results = 8'hD4;
        run_sweep(0, 8'h94);
        check("chk_fail", {mismatch, pass}, {4'b1000, 1'b0});
`endif

        // randomized table contents and abort timing against the edge model
        for (int r = 0; r < 24; r++) begin
            l  = 8'($urandom);
            k  = $urandom_range(0, 24);
            d0 = done_total;
            run_sweep(k, l);
            check($sformatf("rnd%0d_results", r), results, model_results(l, k));
            check($sformatf("rnd%0d_done", r), done_total - d0,
                  (k == 0 || k > 20) ? 1 : 0);
            check($sformatf("rnd%0d_vec", r), {busy, dut_in1, dut_in2, step_idx},
                  (k == 0 || k > 21) ? {1'b0, 2'b11, 2'b11} : {1'b0, 2'b00, 2'b00});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
